// File: rtl/ttl_cen_sequencer.sv
// Fractional-rate clock-enable scheduler with phase strobes and board-level clear sequencing.
// Produces cen/cenb pulses from a num/den accumulator and holds clrn_out low for RST_HOLD cen pulses.
module ttl_cen_sequencer #(
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned NPH      = 4,
  parameter int unsigned PH_W     = 2,
  parameter int unsigned RST_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  input  logic             soft_rst_req,
  output logic             cen,
  output logic             cenb,
  output logic [NPH-1:0]   phase,
  output logic [PH_W-1:0]  phase_idx,
  output logic             clrn_out,
  output logic             ready,
  output logic             cfg_err
);

  localparam int unsigned HC_W = 8;

  typedef enum logic {HOLD, RUN} state_t;

  state_t            state, state_nx;
  logic [ACC_W-1:0]  acc, acc_nx;
  logic [HC_W-1:0]   hold_cnt, hold_nx;
  logic [PH_W-1:0]   idx_nx;
  logic [NPH-1:0]    phase_nx;
  logic              cen_nx, cenb_nx, cfg_err_nx, clrn_nx;
  logic              run_en, wrap;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  half;

  // State and datapath registers; every output is taken straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HOLD;
      acc       <= '0;
      hold_cnt  <= '0;
      phase_idx <= '0;
      phase     <= '0;
      cen       <= 1'b0;
      cenb      <= 1'b0;
      cfg_err   <= 1'b0;
      clrn_out  <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      hold_cnt  <= hold_nx;
      phase_idx <= idx_nx;
      phase     <= phase_nx;
      cen       <= cen_nx;
      cenb      <= cenb_nx;
      cfg_err   <= cfg_err_nx;
      clrn_out  <= clrn_nx;
      ready     <= clrn_nx;
    end
  end

  // Next-state, accumulator step and phase/clear sequencing.
  always_comb begin
    run_en     = enable & ~cfg_err;
    sum        = {1'b0, acc} + {1'b0, num};
    half       = den >> 1;
    wrap       = (sum >= {1'b0, den});
    state_nx   = state;
    acc_nx     = acc;
    hold_nx    = hold_cnt;
    idx_nx     = phase_idx;
    phase_nx   = '0;
    cen_nx     = 1'b0;
    cenb_nx    = 1'b0;
    cfg_err_nx = (num == '0) | (den == '0) | ({num, 1'b0} > {1'b0, den});

    if (run_en) begin
      acc_nx  = wrap ? ACC_W'(sum - {1'b0, den}) : ACC_W'(sum);
      cen_nx  = wrap;
      cenb_nx = (acc < half) && (sum >= {1'b0, half}) && !wrap;
      if (wrap) begin
        phase_nx = NPH'(1) << phase_idx;
        idx_nx   = (phase_idx == PH_W'(NPH - 1)) ? '0 : phase_idx + PH_W'(1);
      end
    end

    case (state)
      HOLD: begin
        // Count delivered cen pulses; soft reset requests are ignored here.
        if (run_en && cen) begin
          if (hold_cnt == HC_W'(RST_HOLD - 1)) begin
            state_nx = RUN;
            hold_nx  = '0;
          end else begin
            hold_nx  = hold_cnt + HC_W'(1);
          end
        end
      end
      RUN: begin
        if (soft_rst_req) begin
          state_nx = HOLD;
          idx_nx   = '0;
          hold_nx  = '0;
        end
      end
      default: state_nx = HOLD;
    endcase

    clrn_nx = (state_nx == RUN);
  end

endmodule
